decode: RTL and testbench

Instruction-decode stage of the five-stage pipeline; sits directly downstream of the fetch stage and consumes its `IFIDIR` register. Each cycle it reads the two source operands from the integrated register file and sign-extends the immediate into the ID/EX pipeline registers. It also detects load-use hazards and drives the `stall` input of fetch. On a taken jump or branch it injects a bubble into ID/EX, in step with fetch's own NOP injection.

---
 rtl/pipeline_pkg.sv | 42 ++++
 rtl/regfile.sv | 64 ++++++
 rtl/decode.sv | 124 ++++++++++++
 tb/tb_decode.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared definitions for the five-stage pipeline: opcode constants, the
//   canonical NOP encoding and helpers that pull fields out of an
//   instruction word and classify which source registers an opcode reads.
package pipeline_pkg;

    localparam logic [5:0]  OP_ALU = 6'd0;
    localparam logic [5:0]  OP_BEQ = 6'd4;
    localparam logic [5:0]  OP_LW  = 6'd35;
    localparam logic [5:0]  OP_SW  = 6'd43;

    // ALU-format "add r0,r0,r0": harmless bubble with no register sources
    // that could ever match a load destination other than r0.
    localparam logic [31:0] no_op  = 32'h0000_0020;

    function automatic logic [5:0] get_op(input logic [31:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [4:0] get_rs(input logic [31:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] get_rt(input logic [31:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [15:0] get_imm(input logic [31:0] ir);
        return ir[15:0];
    endfunction

    // rs is a source for every opcode this pipeline implements.
    function automatic logic uses_rs(input logic [5:0] op);
        return (op == OP_ALU) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

    // rt is a destination for LW, so it only counts as a source for these.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_ALU) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/regfile.sv
// regfile
//   32 x DATA_W register file with two combinational read ports and one
//   synchronous write port. r0 reads as zero and ignores writes. All
//   registers clear on asynchronous reset.
//
//   Configuration macro: DECODE_WB_BYPASS_EN
//     defined   - a read of the register being written this cycle returns
//                 the write data combinationally.
//     undefined - reads return the stored (pre-write) contents.
//
//   Ports
//     clk, rst_n      clock, asynchronous active-low reset
//     i_wb_en         write enable
//     i_wb_reg        write address
//     i_wb_data       write data
//     i_rs, i_rt      read addresses
//     o_rs_data       read data for i_rs
//     o_rt_data       read data for i_rt
module regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wb_en,
    input  logic [4:0]        i_wb_reg,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic [4:0]        i_rs,
    input  logic [4:0]        i_rt,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data
);

    logic [DATA_W-1:0] r_mem [32];
    logic [DATA_W-1:0] w_rs_stored;
    logic [DATA_W-1:0] w_rt_stored;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wb_en && (i_wb_reg != 5'd0)) begin
            r_mem[i_wb_reg] <= i_wb_data;
        end
    end

    // r0 is forced to zero on the read side so the storage entry never matters.
    assign w_rs_stored = (i_rs == 5'd0) ? '0 : r_mem[i_rs];
    assign w_rt_stored = (i_rt == 5'd0) ? '0 : r_mem[i_rt];

`ifdef DECODE_WB_BYPASS_EN
    logic w_byp_rs;
    logic w_byp_rt;

    assign w_byp_rs  = i_wb_en && (i_wb_reg != 5'd0) && (i_wb_reg == i_rs);
    assign w_byp_rt  = i_wb_en && (i_wb_reg != 5'd0) && (i_wb_reg == i_rt);
    assign o_rs_data = w_byp_rs ? i_wb_data : w_rs_stored;
    assign o_rt_data = w_byp_rt ? i_wb_data : w_rt_stored;
`else
    assign o_rs_data = w_rs_stored;
    assign o_rt_data = w_rt_stored;
`endif

endmodule

// File: rtl/decode.sv
// decode
//   Instruction-decode stage. Reads rs/rt from the integrated register file,
//   sign-extends the immediate and loads the ID/EX registers. Detects
//   load-use hazards (stall to fetch, bubble into ID/EX) and flushes ID/EX
//   when a control transfer resolves in MEM. Counts stall cycles with a
//   saturating counter.
//
//   Configuration macro: DECODE_WB_BYPASS_EN (same-cycle writeback bypass
//   inside the register file; see regfile).
//
//   Ports
//     clk, rst_n      clock, asynchronous active-low reset
//     IFIDIR          instruction from fetch
//     ijmpMem         flush request (taken jump/branch in MEM)
//     wb_en, wb_reg, wb_data   writeback port from WB
//     stall           combinational load-use hazard, to fetch
//     IDEXIR          registered instruction for EX
//     IDEXA, IDEXB    registered rs / rt operands
//     IDEXimm         registered sign-extended immediate
//     stall_count     saturating count of stall cycles
module decode
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       IFIDIR,
    input  logic              ijmpMem,
    input  logic              wb_en,
    input  logic [4:0]        wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic [31:0]       IDEXIR,
    output logic [DATA_W-1:0] IDEXA,
    output logic [DATA_W-1:0] IDEXB,
    output logic [DATA_W-1:0] IDEXimm,
    output logic [CNT_W-1:0]  stall_count
);

    logic [31:0]       r_idex_ir;
    logic [DATA_W-1:0] r_idex_a;
    logic [DATA_W-1:0] r_idex_b;
    logic [DATA_W-1:0] r_idex_imm;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [5:0]        w_if_op;
    logic [4:0]        w_if_rs;
    logic [4:0]        w_if_rt;
    logic [15:0]       w_if_imm;
    logic [4:0]        w_ex_rt;
    logic              w_ex_is_load;
    logic              w_rs_hit;
    logic              w_rt_hit;
    logic              w_stall;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic [DATA_W-1:0] w_imm_sext;

    assign w_if_op  = get_op(IFIDIR);
    assign w_if_rs  = get_rs(IFIDIR);
    assign w_if_rt  = get_rt(IFIDIR);
    assign w_if_imm = get_imm(IFIDIR);
    assign w_ex_rt  = get_rt(r_idex_ir);

    regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wb_en   (wb_en),
        .i_wb_reg  (wb_reg),
        .i_wb_data (wb_data),
        .i_rs      (w_if_rs),
        .i_rt      (w_if_rt),
        .o_rs_data (w_rs_data),
        .o_rt_data (w_rt_data)
    );

    // Load in EX whose destination feeds a source of the instruction in ID.
    // A load to r0 never stalls: its result is discarded. A flush wins, since
    // the dependent instruction is being squashed anyway.
    assign w_ex_is_load = (get_op(r_idex_ir) == OP_LW) && (w_ex_rt != 5'd0);
    assign w_rs_hit     = uses_rs(w_if_op) && (w_if_rs == w_ex_rt);
    assign w_rt_hit     = uses_rt(w_if_op) && (w_if_rt == w_ex_rt);
    assign w_stall      = w_ex_is_load && (w_rs_hit || w_rt_hit) && !ijmpMem;

    assign w_imm_sext   = {{(DATA_W-16){w_if_imm[15]}}, w_if_imm};

    // Bubbles (flush or stall) only replace the instruction; operands are
    // held so they do not toggle for an instruction nobody will use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex_ir  <= no_op;
            r_idex_a   <= '0;
            r_idex_b   <= '0;
            r_idex_imm <= '0;
        end else if (ijmpMem || w_stall) begin
            r_idex_ir  <= no_op;
        end else begin
            r_idex_ir  <= IFIDIR;
            r_idex_a   <= w_rs_data;
            r_idex_b   <= w_rt_data;
            r_idex_imm <= w_imm_sext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall       = w_stall;
    assign IDEXIR      = r_idex_ir;
    assign IDEXA       = r_idex_a;
    assign IDEXB       = r_idex_b;
    assign IDEXimm     = r_idex_imm;
    assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_decode.sv
module tb_decode;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

`ifdef DECODE_WB_BYPASS_EN
    localparam logic [31:0] R2_SAME_CYCLE = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] R2_SAME_CYCLE = 32'h0000_0007;
`endif

    // clock / reset
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT
    logic [31:0]       ifidir;
    logic              ijmp_mem;
    logic              wb_en;
    logic [4:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              stall;
    logic [31:0]       idex_ir;
    logic [DATA_W-1:0] idex_a;
    logic [DATA_W-1:0] idex_b;
    logic [DATA_W-1:0] idex_imm;
    logic [CNT_W-1:0]  stall_count;

    decode #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .IFIDIR      (ifidir),
        .ijmpMem     (ijmp_mem),
        .wb_en       (wb_en),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .stall       (stall),
        .IDEXIR      (idex_ir),
        .IDEXA       (idex_a),
        .IDEXB       (idex_b),
        .IDEXimm     (idex_imm),
        .stall_count (stall_count)
    );

    // scoreboard
    typedef struct packed {
        logic              stall;   // combinational stall during the cycle
        logic [31:0]       ir;      // registered values after the edge
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic [CNT_W-1:0]  cnt;
        logic              chk_ops; // 0 when operands are don't-care (flush)
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic s_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // monitor: stall is sampled mid-cycle, registered outputs just after the edge
    always @(negedge clk) s_stall = stall;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("stall",       {31'b0, s_stall},   {31'b0, e.stall});
            check("IDEXIR",      idex_ir,            e.ir);
            check("stall_count", {16'b0, stall_count}, {16'b0, e.cnt});
            if (e.chk_ops) begin
                check("IDEXA",   idex_a,   e.a);
                check("IDEXB",   idex_b,   e.b);
                check("IDEXimm", idex_imm, e.imm);
            end
        end
    end

    // driver: apply one cycle of inputs and queue the expected response
    task automatic step(input logic [31:0] ir, input logic jmp,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic e_stall, input logic [31:0] e_ir,
                        input logic [31:0] e_a, input logic [31:0] e_b,
                        input logic [31:0] e_imm, input logic [15:0] e_cnt,
                        input logic e_chk);
        exp_t e;
        @(posedge clk);
        #2;
        ifidir   = ir;
        ijmp_mem = jmp;
        wb_en    = we;
        wb_reg   = wr;
        wb_data  = wd;
        e.stall   = e_stall;
        e.ir      = e_ir;
        e.a       = e_a;
        e.b       = e_b;
        e.imm     = e_imm;
        e.cnt     = e_cnt;
        e.chk_ops = e_chk;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_IDEXIR"}, idex_ir, 32'h0000_0020);
        check({tag, "_IDEXA"},  idex_a,  32'h0);
        check({tag, "_IDEXB"},  idex_b,  32'h0);
        check({tag, "_IDEXimm"}, idex_imm, 32'h0);
        check({tag, "_stall"},  {31'b0, stall}, 32'h0);
        check({tag, "_cnt"},    {16'b0, stall_count}, 32'h0);
    endtask

    localparam logic [31:0] NOP    = 32'h0000_0020;
    localparam logic [31:0] ADD312 = 32'h0022_1820; // add r3,r1,r2
    localparam logic [31:0] ADD324 = 32'h0044_1820; // add r3,r2,r4
    localparam logic [31:0] ADD350 = 32'h00A0_1820; // add r3,r5,r0
    localparam logic [31:0] LW21   = 32'h8C22_0000; // lw r2,0(r1)
    localparam logic [31:0] LW52   = 32'h8C45_0004; // lw r5,4(r2)
    localparam logic [31:0] LW24   = 32'h8C82_0000; // lw r2,0(r4)
    localparam logic [31:0] LW01   = 32'h8C20_0000; // lw r0,0(r1)
    localparam logic [31:0] LW21N  = 32'h8C22_FFFC; // lw r2,-4(r1)

    initial begin
        rst_n    = 1'b0;
        ifidir   = ADD324;
        ijmp_mem = 1'b0;
        wb_en    = 1'b0;
        wb_reg   = 5'd0;
        wb_data  = '0;
        #12;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        //    IFIDIR  jmp we reg wdata          stall IR      A         B              imm           cnt chk
        step(NOP,    0, 1, 1, 32'd5,          0, NOP,    0,        0,             32'h20,       0, 1);
        step(NOP,    0, 1, 2, 32'd7,          0, NOP,    0,        0,             32'h20,       0, 1);
        step(ADD312, 0, 0, 0, 0,              0, ADD312, 5,        7,             32'h1820,     0, 1);
        step(LW21,   0, 0, 0, 0,              0, LW21,   5,        7,             0,            0, 1);
        step(ADD324, 0, 0, 0, 0,              1, NOP,    5,        7,             0,            1, 1);
        step(ADD324, 0, 0, 0, 0,              0, ADD324, 7,        0,             32'h1820,     1, 1);
        step(LW21,   0, 0, 0, 0,              0, LW21,   5,        7,             0,            1, 1);
        step(LW52,   0, 0, 0, 0,              1, NOP,    5,        7,             0,            2, 1);
        step(LW52,   0, 0, 0, 0,              0, LW52,   7,        0,             4,            2, 1);
        step(ADD350, 0, 0, 0, 0,              1, NOP,    7,        0,             4,            3, 1);
        step(ADD350, 0, 0, 0, 0,              0, ADD350, 0,        0,             32'h1820,     3, 1);
        step(LW21,   0, 0, 0, 0,              0, LW21,   5,        7,             0,            3, 1);
        step(LW24,   0, 0, 0, 0,              0, LW24,   0,        7,             0,            3, 1);
        step(ADD324, 1, 0, 0, 0,              0, NOP,    0,        0,             0,            3, 0);
        step(ADD324, 0, 0, 0, 0,              0, ADD324, 7,        0,             32'h1820,     3, 1);
        step(LW01,   0, 0, 0, 0,              0, LW01,   5,        0,             0,            3, 1);
        step(NOP,    0, 0, 0, 0,              0, NOP,    0,        0,             32'h20,       3, 1);
        step(ADD312, 0, 1, 2, 32'hDEADBEEF,   0, ADD312, 5,        R2_SAME_CYCLE, 32'h1820,     3, 1);
        step(ADD312, 0, 1, 0, 32'h12345678,   0, ADD312, 5,        32'hDEADBEEF,  32'h1820,     3, 1);
        step(NOP,    0, 1, 0, 32'hFFFFFFFF,   0, NOP,    0,        0,             32'h20,       3, 1);
        step(LW21N,  0, 0, 0, 0,              0, LW21N,  5,        32'hDEADBEEF,  32'hFFFFFFFC, 3, 1);
        drain();

        // hazard present, then reset lands mid-cycle before the stalling edge
        ifidir = ADD324;
        @(negedge clk);
        #1;
        check("midstall_stall", {31'b0, stall}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // register file was cleared along with the pipeline registers
        step(ADD312, 0, 0, 0, 0,              0, ADD312, 0,        0,             32'h1820,     0, 1);
        step(ADD324, 0, 0, 0, 0,              0, ADD324, 0,        0,             32'h1820,     0, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
